data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Sequencer and arbiter in front of the 8-word x 32-bit data memory used by the MEM stage.
- Shares the memory between two requesters:
  - the pipeline load/store port, which has priority;
  - a debug/loader port, used for program/data preload and inspection.
- Inserts configurable wait states and raises a stall to the pipeline while its access is pending.
- Rejects out-of-range addresses without touching memory.

Parameters:
DEPTH, 8, number of 32-bit words in the data memory
ADDR_W, 3, memory index width (log2 DEPTH)
WAIT_STATES, 1, extra cycles per access (0..15)
STARVE_LIMIT, 4, consecutive pipeline wins while debug waits before debug is forced a grant (1..15)

Ports:
clk  in  1  clock, all state on posedge
resetN  in  1  asynchronous, active-low reset
pipeReq  in  1  pipeline request; held until pipeAck
pipeWrite  in  1  1 = store, 0 = load
pipeAddr  in  32  word address (ALU result)
pipeWdata  in  32  store data
pipeAck  out  1  one-cycle completion pulse
pipeRdata  out  32  load data, valid from pipeAck until the next pipeline load completes
pipeStall  out  1  pipeReq & ~pipeAck (combinational)
dbgReq  in  1  debug request; held until dbgAck
dbgWrite  in  1  1 = write, 0 = read
dbgAddr  in  32  word address
dbgWdata  in  32  write data
dbgAck  out  1  one-cycle completion pulse
dbgRdata  out  32  read data, same validity rule as pipeRdata
memAddr  out  ADDR_W  index to memory array
memWdata  out  32  write data to array
memWe  out  1  array write enable (array writes on posedge when high)
memRdata  in  32  combinational array read of memAddr
addrError  out  1  pulses with the ack of a rejected (out-of-range) access

Behaviour:
- Reset (resetN low, async): state IDLE; counters 0; memAddr, memWdata, pipeRdata, dbgRdata = 0; memWe, pipeAck, dbgAck, addrError = 0.
  - Any in-flight access is dropped; no write occurs.
- pipeStall stays combinational during reset.
- FSM IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If any req is high, choose a winner.
  - Latch owner, write flag, addr, wdata and inRange = (addr < DEPTH).
  - Load waitCnt = WAIT_STATES and go to ACCESS.
  - If no req is high, stay in IDLE.
- Arbitration: pipeline wins by default.
  - Debug wins if pipeReq is low, or if both are high and starveCnt == STARVE_LIMIT.
  - starveCnt: +1 on a pipeline grant while dbgReq is high; cleared on a debug grant, or on a pipeline grant with dbgReq low.
  - starveCnt saturates at STARVE_LIMIT.
- ACCESS:
  - memAddr = latched addr[ADDR_W-1:0]; memWdata = latched wdata.
  - waitCnt decrements each cycle.
  - Final cycle (waitCnt == 0): memWe = write & inRange, high for exactly one cycle.
  - Final cycle, read: owner's rdata register captures memRdata if inRange, else 0.
  - After the final cycle, go to DONE.
- DONE:
  - Owner's ack = 1 and addrError = ~inRange for this single cycle.
  - Requests are not sampled in DONE; go to IDLE.
- Latency: req first high in IDLE cycle T -> ack high in cycle T + WAIT_STATES + 2.
  - A new request can be sampled no earlier than cycle T + WAIT_STATES + 3.
- Requester obligations:
  - Deassert req (or present the next request) on the edge after ack.
  - Address, data and write must be stable while req is high. The arbiter latches them at grant and ignores later changes.
- Simultaneous requests: one grant per transaction; the loser keeps waiting with its req high. pipeStall remains high for a losing pipeline request.
- Read of a write access: the owner's rdata is unchanged.
- Out of range: addr >= DEPTH, i.e. any upper bit set (including 32'hFFFFFFFF). No memory write; read returns 0; addrError pulses.
- Latency is the same for in-range and rejected accesses.
- memAddr/memWdata hold their last value outside ACCESS. memWe is 0 outside ACCESS.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2);
  - owner encoding (OWN_PIPE = 0, OWN_DBG = 1);
  - DEPTH/ADDR_W defaults, shared with the memory stage.
- One natural sub-module: mem_grant_select. This is combinational priority plus starvation logic: inputs pipeReq, dbgReq, starveCnt; outputs grant valid and owner.
- The FSM, counters and latches stay in data_mem_arbiter.

Test Plan:
- Reset, then pipeline store (addr 5, data 32'hDEADBEEF), WAIT_STATES = 1:
  - memWe high in exactly one cycle, with memAddr = 5;
  - pipeAck 3 cycles after req;
  - pipeStall high for 3 cycles.
- Pipeline load from addr 5 after the store -> pipeRdata = 32'hDEADBEEF at pipeAck; dbgRdata unchanged; addrError = 0.
- pipeReq and dbgReq held continuously, STARVE_LIMIT = 4:
  - grant order P, P, P, P, D, P, P, P, P, D;
  - no overlapping acks.
- Debug write to addr 8, then pipeline read of addr 32'hFFFFFFFF:
  - no memWe ever asserted;
  - addrError pulses with each ack;
  - pipeRdata = 0.
- resetN pulsed low during the ACCESS state of a store:
  - all outputs return to 0 immediately;
  - memWe never asserts;
  - after release, a re-issued request completes normally.
- WAIT_STATES = 0, back-to-back pipeline loads of addrs 0 to 7 -> each ack 2 cycles after its req; pipeRdata = preloaded contents in order.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared encodings and size defaults for the MEM-stage data memory arbiter.
// DEPTH/ADDR_W defaults are also used by the memory array itself.
package data_mem_arbiter_pkg;

    localparam int DEPTH_DEF  = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_PIPE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_e;

endpackage

// File: rtl/data_mem_arbiter_grant.sv
// Priority select between pipeline and debug requesters. The pipeline wins
// unless debug has been passed over STARVE_LIMIT times in a row.
module mem_grant_select
    import data_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic             pipeReq,
    input  logic             dbgReq,
    input  logic [CNT_W-1:0] starveCnt,
    output logic             grantValid,
    output owner_e           grantOwner
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    always_comb begin
        grantValid = pipeReq | dbgReq;
        grantOwner = OWN_PIPE;
        if (dbgReq && (!pipeReq || (starveCnt == LIMIT))) begin
            grantOwner = OWN_DBG;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Sequences pipeline and debug accesses onto the shared data memory with
// configurable wait states; out-of-range accesses complete without touching memory.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int WAIT_STATES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              pipeReq,
    input  logic              pipeWrite,
    input  logic [31:0]       pipeAddr,
    input  logic [31:0]       pipeWdata,
    output logic              pipeAck,
    output logic [31:0]       pipeRdata,
    output logic              pipeStall,
    input  logic              dbgReq,
    input  logic              dbgWrite,
    input  logic [31:0]       dbgAddr,
    input  logic [31:0]       dbgWdata,
    output logic              dbgAck,
    output logic [31:0]       dbgRdata,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memWdata,
    output logic              memWe,
    input  logic [31:0]       memRdata,
    output logic              addrError
);

    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    state_e            state_q;
    owner_e            owner_q;
    logic              write_q;
    logic              inRange_q;
    logic [CNT_W-1:0]  waitCnt_q;
    logic [CNT_W-1:0]  starveCnt_q;
    logic [CNT_W-1:0]  starveCnt_d;
    logic [ADDR_W-1:0] memAddr_q;
    logic [31:0]       memWdata_q;
    logic [31:0]       pipeRdata_q;
    logic [31:0]       dbgRdata_q;
    logic              memWe_q;
    logic              pipeAck_q;
    logic              dbgAck_q;
    logic              addrError_q;

    logic              grantValid;
    owner_e            grantOwner;
    logic              selWrite;
    logic [31:0]       selAddr;
    logic [31:0]       selWdata;
    logic              selInRange;
    logic [31:0]       rdataSel;

    mem_grant_select #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_grant (
        .pipeReq    (pipeReq),
        .dbgReq     (dbgReq),
        .starveCnt  (starveCnt_q),
        .grantValid (grantValid),
        .grantOwner (grantOwner)
    );

    always_comb begin
        selWrite = pipeWrite;
        selAddr  = pipeAddr;
        selWdata = pipeWdata;
        if (grantOwner == OWN_DBG) begin
            selWrite = dbgWrite;
            selAddr  = dbgAddr;
            selWdata = dbgWdata;
        end
        selInRange = (selAddr < 32'(DEPTH));
        rdataSel   = inRange_q ? memRdata : 32'd0;

        // Starvation only accumulates while debug is actually waiting.
        starveCnt_d = starveCnt_q;
        if ((grantOwner == OWN_DBG) || !dbgReq) begin
            starveCnt_d = '0;
        end else if (starveCnt_q != STARVE_MAX) begin
            starveCnt_d = starveCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_PIPE;
            write_q     <= 1'b0;
            inRange_q   <= 1'b0;
            waitCnt_q   <= '0;
            starveCnt_q <= '0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            pipeRdata_q <= '0;
            dbgRdata_q  <= '0;
            memWe_q     <= 1'b0;
            pipeAck_q   <= 1'b0;
            dbgAck_q    <= 1'b0;
            addrError_q <= 1'b0;
        end else begin
            memWe_q     <= 1'b0;
            pipeAck_q   <= 1'b0;
            dbgAck_q    <= 1'b0;
            addrError_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (grantValid) begin
                        owner_q     <= grantOwner;
                        write_q     <= selWrite;
                        inRange_q   <= selInRange;
                        memAddr_q   <= selAddr[ADDR_W-1:0];
                        memWdata_q  <= selWdata;
                        waitCnt_q   <= WAIT_LOAD;
                        starveCnt_q <= starveCnt_d;
                        // With no wait states the first ACCESS cycle is also the last.
                        memWe_q     <= (WAIT_LOAD == '0) && selWrite && selInRange;
                        state_q     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (waitCnt_q == '0) begin
                        if (!write_q) begin
                            if (owner_q == OWN_DBG) dbgRdata_q  <= rdataSel;
                            else                    pipeRdata_q <= rdataSel;
                        end
                        pipeAck_q   <= (owner_q == OWN_PIPE);
                        dbgAck_q    <= (owner_q == OWN_DBG);
                        addrError_q <= !inRange_q;
                        state_q     <= ST_DONE;
                    end else begin
                        waitCnt_q <= waitCnt_q - CNT_W'(1);
                        memWe_q   <= (waitCnt_q == CNT_W'(1)) && write_q && inRange_q;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pipeAck   = pipeAck_q;
    assign dbgAck    = dbgAck_q;
    assign pipeRdata = pipeRdata_q;
    assign dbgRdata  = dbgRdata_q;
    assign memAddr   = memAddr_q;
    assign memWdata  = memWdata_q;
    assign memWe     = memWe_q;
    assign addrError = addrError_q;
    assign pipeStall = pipeReq & ~pipeAck_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized self-checking bench for data_mem_arbiter against a transaction-level
// model (memory image, expected rdata registers, starvation count).
module tb_data_mem_arbiter;

    localparam int WS = 1;
    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        resetN;

    logic        pipeReq, pipeWrite, dbgReq, dbgWrite;
    logic [31:0] pipeAddr, pipeWdata, dbgAddr, dbgWdata;
    logic        pipeAck, pipeStall, dbgAck, memWe, addrError;
    logic [31:0] pipeRdata, dbgRdata, memWdata, memRdata;
    logic [2:0]  memAddr;
    logic [31:0] memA [8];

    logic        pipeReqB, pipeWriteB, dbgReqB, dbgWriteB;
    logic [31:0] pipeAddrB, pipeWdataB, dbgAddrB, dbgWdataB;
    logic        pipeAckB, pipeStallB, dbgAckB, memWeB, addrErrorB;
    logic [31:0] pipeRdataB, dbgRdataB, memWdataB, memRdataB;
    logic [2:0]  memAddrB;
    logic [31:0] memB [8];

    int          total = 0;
    int          bad = 0;
    int          weCnt = 0;
    int          stallCnt = 0;
    logic [2:0]  lastWeAddr = '0;

    logic [31:0] refMem [8];
    logic [31:0] refB [8];
    logic [31:0] expP, expD;
    int          expWe, starve;

    always #5 clk = ~clk;

    data_mem_arbiter #(.DEPTH(8), .ADDR_W(3), .WAIT_STATES(WS), .STARVE_LIMIT(SL)) dutA (
        .clk(clk), .resetN(resetN),
        .pipeReq(pipeReq), .pipeWrite(pipeWrite), .pipeAddr(pipeAddr), .pipeWdata(pipeWdata),
        .pipeAck(pipeAck), .pipeRdata(pipeRdata), .pipeStall(pipeStall),
        .dbgReq(dbgReq), .dbgWrite(dbgWrite), .dbgAddr(dbgAddr), .dbgWdata(dbgWdata),
        .dbgAck(dbgAck), .dbgRdata(dbgRdata),
        .memAddr(memAddr), .memWdata(memWdata), .memWe(memWe), .memRdata(memRdata),
        .addrError(addrError)
    );

    data_mem_arbiter #(.DEPTH(8), .ADDR_W(3), .WAIT_STATES(0), .STARVE_LIMIT(SL)) dutB (
        .clk(clk), .resetN(resetN),
        .pipeReq(pipeReqB), .pipeWrite(pipeWriteB), .pipeAddr(pipeAddrB), .pipeWdata(pipeWdataB),
        .pipeAck(pipeAckB), .pipeRdata(pipeRdataB), .pipeStall(pipeStallB),
        .dbgReq(dbgReqB), .dbgWrite(dbgWriteB), .dbgAddr(dbgAddrB), .dbgWdata(dbgWdataB),
        .dbgAck(dbgAckB), .dbgRdata(dbgRdataB),
        .memAddr(memAddrB), .memWdata(memWdataB), .memWe(memWeB), .memRdata(memRdataB),
        .addrError(addrErrorB)
    );

    // Memory arrays the arbiters front: combinational read, posedge write.
    assign memRdata  = memA[memAddr];
    assign memRdataB = memB[memAddrB];
    always @(posedge clk) begin
        if (memWe)  memA[memAddr]  <= memWdata;
        if (memWeB) memB[memAddrB] <= memWdataB;
    end

    always @(negedge clk) begin
        if (memWe) begin
            weCnt++;
            lastWeAddr = memAddr;
        end
        if (pipeStall) stallCnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7)       return 32'($urandom_range(0, 7));
        else if (r == 7) return 32'd8;
        else if (r == 8) return 32'hFFFF_FFFF;
        else             return $urandom | 32'h100;
    endfunction

    // Completion of one access as seen by the model.
    task automatic on_ack(input bit isDbg, input bit wr, input logic [31:0] a, input logic [31:0] d);
        bit inR;
        inR = (a < 32'd8);
        if (wr) begin
            if (inR) begin
                refMem[a[2:0]] = d;
                expWe++;
            end
        end else if (isDbg) begin
            expD = inR ? refMem[a[2:0]] : 32'd0;
        end else begin
            expP = inR ? refMem[a[2:0]] : 32'd0;
        end
        check_eq("pipeRdata", pipeRdata, expP);
        check_eq("dbgRdata", dbgRdata, expD);
        check_eq("addrError", 32'(addrError), 32'(!inR));
        check_eq("weCount", weCnt, expWe);
    endtask

    task automatic txn(input bit pr, input bit dr,
                       input bit pw, input logic [31:0] pa, input logic [31:0] pd,
                       input bit dw, input logic [31:0] da, input logic [31:0] dd);
        bit pendP, pendD, firstDbg, isDbg;
        int cyc, nAck;
        @(posedge clk); #1;
        firstDbg = (pr && dr) ? (starve == SL) : dr;
        if (firstDbg)  starve = 0;
        else if (dr)   starve = (starve < SL) ? starve + 1 : SL;
        else           starve = 0;
        if (pr && dr)  starve = 0;
        pipeWrite = pw; pipeAddr = pa; pipeWdata = pd; pipeReq = pr;
        dbgWrite = dw;  dbgAddr = da;  dbgWdata = dd;  dbgReq = dr;
        pendP = pr; pendD = dr; cyc = 0; nAck = 0;
        while ((pendP || pendD) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            check_eq("ack_overlap", 32'(pipeAck & dbgAck), 32'd0);
            if (pipeAck || dbgAck) begin
                isDbg = dbgAck;
                check_eq("ack_latency", cyc, (nAck == 0) ? WS + 2 : 2 * WS + 5);
                check_eq("ack_owner", 32'(isDbg), 32'((nAck == 0) ? firstDbg : !firstDbg));
                if (isDbg) begin
                    on_ack(1'b1, dw, da, dd);
                    dbgReq = 1'b0; pendD = 1'b0;
                end else begin
                    on_ack(1'b0, pw, pa, pd);
                    pipeReq = 1'b0; pendP = 1'b0;
                end
                nAck++;
            end
        end
        check_eq("txn_timeout", 32'(pendP | pendD), 32'd0);
        pipeReq = 1'b0;
        dbgReq  = 1'b0;
    endtask

    initial begin
        int s0, w0, n, cyc;
        bit expDbg, pr, dr;
        int unsigned sel;

        resetN = 1'b0;
        pipeReq = 1'b1; pipeWrite = 1'b0; pipeAddr = '0; pipeWdata = '0;
        dbgReq = 1'b0;  dbgWrite = 1'b0;  dbgAddr = '0;  dbgWdata = '0;
        pipeReqB = 1'b0; pipeWriteB = 1'b0; pipeAddrB = '0; pipeWdataB = '0;
        dbgReqB = 1'b0;  dbgWriteB = 1'b0;  dbgAddrB = '0;  dbgWdataB = '0;
        expP = '0; expD = '0; expWe = 0; starve = 0;
        for (int i = 0; i < 8; i++) refMem[i] = '0;

        #12;
        check_eq("rst_memWe", 32'(memWe), 32'd0);
        check_eq("rst_pipeAck", 32'(pipeAck), 32'd0);
        check_eq("rst_dbgAck", 32'(dbgAck), 32'd0);
        check_eq("rst_addrError", 32'(addrError), 32'd0);
        check_eq("rst_memAddr", 32'(memAddr), 32'd0);
        check_eq("rst_memWdata", memWdata, 32'd0);
        check_eq("rst_pipeRdata", pipeRdata, 32'd0);
        check_eq("rst_dbgRdata", dbgRdata, 32'd0);
        check_eq("rst_pipeStall_comb", 32'(pipeStall), 32'd1);
        pipeReq = 1'b0;
        @(posedge clk); #1;
        resetN = 1'b1;

        // Preload the array through the debug port.
        for (int i = 0; i < 8; i++) txn(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 32'(i), $urandom);

        s0 = stallCnt; w0 = weCnt;
        txn(1'b1, 1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, 32'd0, 32'd0);
        check_eq("store_stall_cycles", stallCnt - s0, 32'd3);
        check_eq("store_we_pulses", weCnt - w0, 32'd1);
        check_eq("store_we_addr", 32'(lastWeAddr), 32'd5);

        txn(1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 1'b0, 32'd0, 32'd0);
        check_eq("load_deadbeef", pipeRdata, 32'hDEAD_BEEF);

        // Both requesters held continuously: expect debug every fifth grant.
        @(posedge clk); #1;
        pipeReq = 1'b1; pipeWrite = 1'b0; pipeAddr = 32'd2;
        dbgReq = 1'b1;  dbgWrite = 1'b0;  dbgAddr = 32'd6;
        n = 0; cyc = 0;
        while (n < 10 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            check_eq("starve_overlap", 32'(pipeAck & dbgAck), 32'd0);
            if (pipeAck || dbgAck) begin
                expDbg = (starve == SL);
                starve = expDbg ? 0 : ((starve < SL) ? starve + 1 : SL);
                check_eq("grant_order", 32'(dbgAck), 32'(expDbg));
                on_ack(dbgAck, 1'b0, dbgAck ? 32'd6 : 32'd2, 32'd0);
                n++;
            end
        end
        pipeReq = 1'b0; dbgReq = 1'b0;
        check_eq("starve_grants", n, 32'd10);
        starve = 0;

        w0 = weCnt;
        txn(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 32'd8, 32'hCAFE_F00D);
        txn(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0, 32'd0);
        check_eq("oor_no_write", weCnt - w0, 32'd0);
        check_eq("oor_rdata_zero", pipeRdata, 32'd0);

        // Abort a store mid-access with reset.
        @(posedge clk); #1;
        w0 = weCnt;
        pipeReq = 1'b1; pipeWrite = 1'b1; pipeAddr = 32'd3; pipeWdata = 32'h1234_5678;
        @(posedge clk); #1;
        resetN = 1'b0;
        #1;
        check_eq("abort_memWe", 32'(memWe), 32'd0);
        check_eq("abort_memAddr", 32'(memAddr), 32'd0);
        check_eq("abort_memWdata", memWdata, 32'd0);
        check_eq("abort_pipeAck", 32'(pipeAck), 32'd0);
        check_eq("abort_pipeRdata", pipeRdata, 32'd0);
        check_eq("abort_dbgRdata", dbgRdata, 32'd0);
        pipeReq = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetN = 1'b1;
        check_eq("abort_no_write", weCnt - w0, 32'd0);
        expP = '0; expD = '0; starve = 0;
        txn(1'b1, 1'b0, 1'b1, 32'd3, 32'h1234_5678, 1'b0, 32'd0, 32'd0);
        txn(1'b1, 1'b0, 1'b0, 32'd3, 32'd0, 1'b0, 32'd0, 32'd0);

        for (int k = 0; k < 50; k++) begin
            sel = $urandom_range(0, 2);
            pr = (sel != 1);
            dr = (sel != 0);
            txn(pr, dr, 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
                1'($urandom_range(0, 1)), rnd_addr(), $urandom);
        end

        // Zero-wait-state instance: preload, then back-to-back loads.
        for (int i = 0; i < 8; i++) begin
            refB[i] = $urandom;
            @(posedge clk); #1;
            dbgReqB = 1'b1; dbgWriteB = 1'b1; dbgAddrB = 32'(i); dbgWdataB = refB[i];
            cyc = 0;
            do begin @(posedge clk); #1; cyc++; end while (!dbgAckB && cyc < 10);
            check_eq("b_preload_latency", cyc, 32'd2);
            dbgReqB = 1'b0;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        pipeReqB = 1'b1; pipeWriteB = 1'b0; pipeAddrB = 32'd0;
        for (int i = 0; i < 8; i++) begin
            cyc = 0;
            do begin @(posedge clk); #1; cyc++; end while (!pipeAckB && cyc < 10);
            check_eq("b_ack_gap", cyc, (i == 0) ? 32'd2 : 32'd3);
            check_eq("b_rdata", pipeRdataB, refB[i]);
            if (i < 7) pipeAddrB = 32'(i + 1);
            else       pipeReqB = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
